// File: rtl/shift_pkg.sv
// Shared types and funct decode for the shift issue stage.
package shift_pkg;

  localparam logic [5:0] FUNCT_SLL  = 6'b000000;
  localparam logic [5:0] FUNCT_SRL  = 6'b000010;
  localparam logic [5:0] FUNCT_SRA  = 6'b000011;
  localparam logic [5:0] FUNCT_SLLV = 6'b000100;
  localparam logic [5:0] FUNCT_SRLV = 6'b000110;
  localparam logic [5:0] FUNCT_SRAV = 6'b000111;

  typedef struct packed {
    logic legal;
    logic regimm;
    logic leftright;
    logic al;
  } shift_ctrl_t;

  typedef struct packed {
    logic [4:0]  shamt;
    logic [31:0] op_rs;
    logic [31:0] op_rt;
    logic [4:0]  rd;
    logic        regimm;
    logic        leftright;
    logic        al;
    logic        illegal;
  } shift_entry_t;

  // al is driven 1 for left shifts even though the shifter ignores it there.
  function automatic shift_ctrl_t decode_funct(input logic [5:0] funct);
    shift_ctrl_t ctrl;
    ctrl = '0;
    case (funct)
      FUNCT_SLL:  ctrl = '{legal: 1'b1, regimm: 1'b0, leftright: 1'b1, al: 1'b1};
      FUNCT_SRL:  ctrl = '{legal: 1'b1, regimm: 1'b0, leftright: 1'b0, al: 1'b1};
      FUNCT_SRA:  ctrl = '{legal: 1'b1, regimm: 1'b0, leftright: 1'b0, al: 1'b0};
      FUNCT_SLLV: ctrl = '{legal: 1'b1, regimm: 1'b1, leftright: 1'b1, al: 1'b1};
      FUNCT_SRLV: ctrl = '{legal: 1'b1, regimm: 1'b1, leftright: 1'b0, al: 1'b1};
      FUNCT_SRAV: ctrl = '{legal: 1'b1, regimm: 1'b1, leftright: 1'b0, al: 1'b0};
      default:    ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/shift_fifo2.sv
// Two-entry FIFO of decoded shift entries with valid/ready on both sides.
module shift_fifo2
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  shift_entry_t entry_i,
  output logic         wr_ready_o,
  input  logic         pop_i,
  output logic         rd_valid_o,
  output shift_entry_t head_o
);

  localparam logic [1:0] CountFull = 2'(DEPTH);

  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, rd_ptr_q;
  logic         do_push, do_pop;
  shift_entry_t mem_q [2];

  always_comb begin
    // Ready looks only at registered count and reset, never at the pop side.
    wr_ready_o = (count_q != CountFull) && !reset;
    rd_valid_o = (count_q != 2'd0);
    do_push    = push_i && wr_ready_o;
    do_pop     = pop_i && rd_valid_o;
    count_d    = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 2'd1;
    end else if (!do_push && do_pop) begin
      count_d = count_q - 2'd1;
    end
    head_o = mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= ~wr_ptr_q;
      if (do_pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // Storage needs no reset: it is only observed through rd_valid_o.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= entry_i;
  end

endmodule

// File: rtl/shift_issue.sv
// Shift issue stage: decodes R-type shifts, queues them and drives the barrel shifter.
// Define SHIFT_ILLEGAL_TRAP_EN to enqueue non-shift functs as illegal (adds out_illegal).
module shift_issue
  import shift_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_funct,
  input  logic [4:0]  in_shamt,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_rd,
  output logic [4:0]  sh_sh,
  output logic [31:0] sh_rs,
  output logic [31:0] sh_rt,
  output logic        sh_regimm,
  output logic        sh_leftright,
  output logic        sh_al,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd
`ifdef SHIFT_ILLEGAL_TRAP_EN
  ,
  output logic        out_illegal
`endif
);

  shift_ctrl_t  ctrl;
  shift_entry_t entry, head;
  logic         fifo_ready, head_valid, push;

  always_comb begin
    ctrl          = decode_funct(in_funct);
    entry         = '0;
    entry.rd      = in_rd;
    entry.illegal = !ctrl.legal;
    if (ctrl.legal) begin
      entry.shamt     = in_shamt;
      entry.op_rs     = in_rs;
      entry.op_rt     = in_rt;
      entry.regimm    = ctrl.regimm;
      entry.leftright = ctrl.leftright;
      entry.al        = ctrl.al;
    end
  end

`ifdef SHIFT_ILLEGAL_TRAP_EN
  assign push = in_valid && fifo_ready;
`else
  // Non-shift functs still handshake but are dropped here.
  assign push = in_valid && fifo_ready && ctrl.legal;
`endif

  shift_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push_i     (push),
    .entry_i    (entry),
    .wr_ready_o (fifo_ready),
    .pop_i      (out_ready),
    .rd_valid_o (head_valid),
    .head_o     (head)
  );

  assign in_ready  = fifo_ready;
  assign out_valid = head_valid;

  // Shifter's rs port takes the value to shift, its rt port the amount source.
  always_comb begin
    sh_sh        = '0;
    sh_rs        = '0;
    sh_rt        = '0;
    sh_regimm    = 1'b0;
    sh_leftright = 1'b0;
    sh_al        = 1'b0;
    out_rd       = '0;
    if (head_valid) begin
      sh_sh        = head.shamt;
      sh_rs        = head.op_rt;
      sh_rt        = head.op_rs;
      sh_regimm    = head.regimm;
      sh_leftright = head.leftright;
      sh_al        = head.al;
      out_rd       = head.rd;
    end
  end

`ifdef SHIFT_ILLEGAL_TRAP_EN
  assign out_illegal = head.illegal && head_valid;
`else
  logic unused_illegal;
  assign unused_illegal = head.illegal;
`endif

endmodule
